seq_divider: RTL and testbench
==============================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter NA, default 8: dividend and quotient width in bits, two's complement, NA >= 2.
REQ-002 SHALL have parameter NB, default 8: divisor and remainder width in bits, two's complement, 2 <= NB <= NA.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port A_in, input, NA: signed dividend, sampled on acceptance.
REQ-006 SHALL have port B_in, input, NB: signed divisor, sampled on acceptance.
REQ-007 SHALL have port in_valid, input, 1: operands on A_in/B_in are valid.
REQ-008 SHALL have port in_ready, output, 1: block can accept operands.
REQ-009 SHALL have port Q_out, output, NA: signed quotient, truncated toward zero.
REQ-010 SHALL have port R_out, output, NB: signed remainder; sign follows dividend, or zero.
REQ-011 SHALL have port div_zero, output, 1: current result came from divisor zero.
REQ-012 SHALL have port ovf, output, 1: current result is the -2^(NA-1) / -1 case.
REQ-013 SHALL have port out_valid, output, 1: Q_out/R_out/flags are valid.
REQ-014 SHALL have port out_ready, input, 1: consumer accepts the result.

Function
REQ-015 SHALL implement states IDLE, PREP, ITER, FIX, DONE.
REQ-016 SHALL assert in_ready only in IDLE; acceptance = in_valid && in_ready at a rising edge: capture operands, go to PREP.
REQ-017 PREP SHALL latch |A|, |B|, the quotient sign (sign A XOR sign B) and the remainder sign (sign A), load iteration counter with NA-1, then go to ITER.
REQ-018 ITER SHALL perform one radix-2 restoring step per cycle: shift the partial remainder left by 1 bit, shifting in the next magnitude-dividend bit, MSB first; subtract |B|; keep the result and set the quotient bit to 1 if non-negative, else restore and set it to 0.
REQ-019 After exactly NA ITER cycles, ITER SHALL go to FIX; the counter SHALL decrement each ITER cycle.
REQ-020 FIX SHALL apply signs (negate the quotient if the quotient sign is set, negate the remainder if the remainder sign is set), register the results and flags, then go to DONE.
REQ-021 Latency SHALL be constant: acceptance at edge k gives out_valid high immediately after edge k+NA+2, for all operands, including the div_zero and ovf cases.
REQ-022 DONE SHALL hold out_valid=1 and keep all outputs stable until out_ready=1 at an edge, then go to IDLE.
REQ-023 No new operand SHALL be accepted in the cycle a result is consumed; the earliest next acceptance is the following edge.
REQ-024 Divisor zero: Q_out = all ones, R_out = 0, div_zero = 1, ovf = 0.
REQ-025 A = -2^(NA-1) with B = -1: Q_out = -2^(NA-1) (wrapped), R_out = 0, ovf = 1, div_zero = 0.
REQ-026 Internal magnitudes SHALL be one bit wider than the operand (NA+1 bits for the dividend, NB+1 for the divisor) so that the most-negative value has a representable absolute value.
REQ-027 out_valid, div_zero and ovf SHALL be 0 in every state except DONE; Q_out and R_out SHALL be don't-care outside DONE but SHALL NOT glitch in DONE.
REQ-028 in_valid outside IDLE SHALL be ignored, with no effect on the running operation.

Reset
REQ-029 With rst=1 at an edge, the block SHALL enter IDLE with in_ready=1, out_valid=0, Q_out=0, R_out=0, div_zero=0, ovf=0, counter=0.
REQ-030 Reset SHALL take priority over every state, including mid-ITER and DONE, and SHALL abort any operation without producing a result.

Structure
REQ-031 Shared package div_pkg SHALL hold the state encoding localparams (3-bit, IDLE=0 ... DONE=4) and the NA/NB defaults.
REQ-032 A single sub-module div_step SHALL implement one combinational shift-subtract-restore step (inputs: partial remainder, next bit, |B|; outputs: new partial remainder, quotient bit); all sequencing SHALL stay in seq_divider.

Verification (NA=NB=8)
REQ-033 Directed scenario: A=100, B=7 -> Q=14, R=2, flags 0, out_valid exactly 10 cycles after acceptance.
REQ-034 Directed scenario: A=-100, B=7 -> Q=-14, R=-2; A=100, B=-7 -> Q=-14, R=2.
REQ-035 Directed scenario: A=100, B=0 -> Q=0xFF, R=0, div_zero=1, same latency as REQ-033.
REQ-036 Directed scenario: A=-128, B=-1 -> Q=0x80, R=0, ovf=1; A=-128, B=1 -> Q=-128, R=0, ovf=0.
REQ-037 Directed scenario: out_ready held low for 5 cycles in DONE -> outputs stable, in_ready=0; then back-to-back operations with in_valid held high -> each accepted exactly one edge after the previous result is consumed.
REQ-038 Directed scenario: rst pulsed during the 4th ITER cycle -> IDLE next cycle, out_valid never asserted, next operation 50/5 -> Q=10, R=0.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider: default widths and
// FSM state encoding.
package div_pkg;

    localparam int NA_DEF = 8;
    localparam int NB_DEF = 8;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PREP = 3'd1;
    localparam logic [2:0] ST_ITER = 3'd2;
    localparam logic [2:0] ST_FIX  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        PREP = ST_PREP,
        ITER = ST_ITER,
        FIX  = ST_FIX,
        DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit,
// trial-subtract the divisor magnitude, keep or restore.
module div_step #(
    parameter int W = 9
) (
    input  logic [W-1:0] rem,
    input  logic         bit_in,
    input  logic [W-1:0] b_mag,
    output logic [W-1:0] rem_nxt,
    output logic         q_bit
);

    logic [W:0] shifted;
    logic [W:0] diff;

    assign shifted = {rem, bit_in};
    assign diff    = shifted - {1'b0, b_mag};
    assign q_bit   = ~diff[W];
    assign rem_nxt = q_bit ? diff[W-1:0] : shifted[W-1:0];

endmodule

// File: rtl/seq_divider.sv
// Sequential signed divider (truncating toward zero) with valid/ready
// handshakes on both sides and a fixed NA+2 cycle latency.
//
// state | meaning
// IDLE  | in_ready high, waiting for operands
// PREP  | latch magnitudes and result signs, load counter
// ITER  | one restoring step per cycle, NA cycles
// FIX   | apply signs and special cases, register results
// DONE  | out_valid high until out_ready
module seq_divider
    import div_pkg::*;
#(
    parameter int NA = NA_DEF,
    parameter int NB = NB_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [NA-1:0] A_in,
    input  logic [NB-1:0] B_in,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [NA-1:0] Q_out,
    output logic [NB-1:0] R_out,
    output logic          div_zero,
    output logic          ovf,
    output logic          out_valid,
    input  logic          out_ready
);

    localparam int CW = $clog2(NA);

    state_t state, state_nxt;

    logic [NA-1:0] a_reg;
    logic [NB-1:0] b_reg;
    logic [NA:0]   a_sh;
    logic [NB:0]   b_mag;
    logic [NB:0]   rem;
    logic [NA-1:0] q_mag;
    logic [CW-1:0] cnt;
    logic          q_neg;
    logic          r_neg;
    logic [NA-1:0] q_out_r;
    logic [NB-1:0] r_out_r;
    logic          dz_r;
    logic          ovf_r;

    logic [NA:0]   a_ext, a_abs;
    logic [NB:0]   b_ext, b_abs;
    logic [NB:0]   rem_nxt;
    logic          q_bit;
    logic          dz_c, ovf_c;

    assign a_ext = {a_reg[NA-1], a_reg};
    assign b_ext = {b_reg[NB-1], b_reg};
    assign a_abs = a_reg[NA-1] ? -a_ext : a_ext;
    assign b_abs = b_reg[NB-1] ? -b_ext : b_ext;
    assign dz_c  = (b_reg == '0);
    assign ovf_c = (a_reg == {1'b1, {(NA-1){1'b0}}}) && (b_reg == '1);

    div_step #(.W(NB + 1)) u_step (
        .rem     (rem),
        .bit_in  (a_sh[NA-1]),
        .b_mag   (b_mag),
        .rem_nxt (rem_nxt),
        .q_bit   (q_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = PREP;
            PREP:    state_nxt = ITER;
            ITER:    if (cnt == '0) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            a_sh    <= '0;
            b_mag   <= '0;
            rem     <= '0;
            q_mag   <= '0;
            cnt     <= '0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            q_out_r <= '0;
            r_out_r <= '0;
            dz_r    <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= A_in;
                        b_reg <= B_in;
                    end
                end
                PREP: begin
                    a_sh  <= a_abs;
                    b_mag <= b_abs;
                    q_neg <= a_reg[NA-1] ^ b_reg[NB-1];
                    r_neg <= a_reg[NA-1];
                    rem   <= '0;
                    q_mag <= '0;
                    cnt   <= CW'(NA - 1);
                end
                ITER: begin
                    rem   <= rem_nxt;
                    q_mag <= {q_mag[NA-2:0], q_bit};
                    // Rotate so the next magnitude bit is always at NA-1.
                    a_sh  <= {a_sh[NA-1:0], a_sh[NA]};
                    cnt   <= cnt - CW'(1);
                end
                FIX: begin
                    dz_r  <= dz_c;
                    ovf_r <= ovf_c;
                    if (dz_c) begin
                        q_out_r <= '1;
                        r_out_r <= '0;
                    end else begin
                        // Most-negative / -1 wraps to itself through the negation.
                        q_out_r <= q_neg ? -q_mag : q_mag;
                        r_out_r <= r_neg ? -rem[NB-1:0] : rem[NB-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign div_zero  = out_valid & dz_r;
    assign ovf       = out_valid & ovf_r;
    assign Q_out     = q_out_r;
    assign R_out     = r_out_r;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: driver pushes reference results, a
// negedge monitor pops and compares whenever out_valid is seen.
module tb_seq_divider;

    localparam int NA = 8;
    localparam int NB = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NA-1:0] A_in = '0;
    logic [NB-1:0] B_in = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [NA-1:0] Q_out;
    logic [NB-1:0] R_out;
    logic          div_zero;
    logic          ovf;
    logic          out_valid;
    logic          out_ready = 1'b1;

    seq_divider #(.NA(NA), .NB(NB)) dut (
        .clk       (clk),
        .rst       (rst),
        .A_in      (A_in),
        .B_in      (B_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Q_out     (Q_out),
        .R_out     (R_out),
        .div_zero  (div_zero),
        .ovf       (ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    typedef struct {
        logic [NA-1:0] q;
        logic [NB-1:0] r;
        logic          dz;
        logic          ov;
        int            acc;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_consume = -1;
    int   prev_accept = -1;
    bit   rand_rdy = 1'b0;
    bit   have_cur = 1'b0;

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: plain integer division, with the two special cases.
    function automatic exp_t model(input logic [NA-1:0] a, input logic [NB-1:0] b, input int acc);
        exp_t e;
        int ai, bi, qi, ri;
        ai = int'($signed(a));
        bi = int'($signed(b));
        e.acc = acc;
        e.dz  = 1'b0;
        e.ov  = 1'b0;
        if (bi == 0) begin
            qi   = -1;
            ri   = 0;
            e.dz = 1'b1;
        end else begin
            qi   = ai / bi;
            ri   = ai % bi;
            e.ov = (qi > (2 ** (NA - 1)) - 1);
        end
        e.q = NA'(qi);
        e.r = NB'(ri);
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic do_op(input logic [NA-1:0] a, input logic [NB-1:0] b);
        bit held;
        int acc;
        int w;
        held     = in_valid;
        A_in     = a;
        B_in     = b;
        in_valid = 1'b1;
        w        = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        acc = cyc + 1;
        if (held && last_consume > prev_accept)
            chk("b2b_accept_edge", acc, last_consume + 1);
        sb.push_back(model(a, b, acc));
        prev_accept = acc;
        @(negedge clk);
        // Junk on the inputs while busy must not disturb the operation.
        A_in = NA'($urandom);
        B_in = NB'($urandom);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((sb.size() != 0 || have_cur) && w < 300) begin
            @(negedge clk);
            w++;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        exp_t          c;
        logic [NA-1:0] sq;
        logic [NB-1:0] sr;
        logic          sdz, sov;
        forever begin
            @(negedge clk);
            #1;
            if (out_valid) begin
                chk("in_ready_in_done", 32'(in_ready), 32'd0);
                if (!have_cur) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_out_valid", 32'(out_valid), 32'd0);
                    end else begin
                        c = sb.pop_front();
                        have_cur = 1'b1;
                        chk("latency", cyc - c.acc, NA + 2);
                        chk("q", 32'(Q_out), 32'(c.q));
                        chk("r", 32'(R_out), 32'(c.r));
                        chk("div_zero", 32'(div_zero), 32'(c.dz));
                        chk("ovf", 32'(ovf), 32'(c.ov));
                        sq  = Q_out;
                        sr  = R_out;
                        sdz = div_zero;
                        sov = ovf;
                    end
                end else begin
                    chk("q_stable", 32'(Q_out), 32'(sq));
                    chk("r_stable", 32'(R_out), 32'(sr));
                    chk("flags_stable", 32'({div_zero, ovf}), 32'({sdz, sov}));
                end
                if (out_ready) begin
                    have_cur = 1'b0;
                    last_consume = cyc + 1;
                end
            end else begin
                chk("flags_low_outside_done", 32'({div_zero, ovf}), 32'd0);
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        logic [NA-1:0] ra;
        logic [NB-1:0] rb;
        int w;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_q", 32'(Q_out), 32'd0);
        chk("rst_r", 32'(R_out), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed chain, in_valid held high between operations.
        do_op(8'd100, 8'd7);
        do_op(-8'sd100, 8'd7);
        do_op(8'd100, -8'sd7);
        do_op(8'd100, 8'd0);
        do_op(8'h80, 8'hFF);
        do_op(8'h80, 8'd1);
        in_valid = 1'b0;
        drain();

        // Consumer stalls for 5 cycles in DONE.
        out_ready = 1'b0;
        do_op(8'd37, -8'sd5);
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        repeat (5) @(negedge clk);
        chk("stall_out_valid_held", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        drain();

        // Reset during the 4th ITER cycle aborts the operation.
        do_op(8'd100, 8'd3);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_q", 32'(Q_out), 32'd0);
        chk("abort_r", 32'(R_out), 32'd0);
        @(negedge clk);
        do_op(8'd50, 8'd5);
        in_valid = 1'b0;
        drain();

        // Random operands with a randomly stalling consumer.
        rand_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 5) == 0) ? 8'h80 : NA'($urandom);
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1:       rb = '1;
                2:       rb = NB'(1);
                default: rb = NB'($urandom);
            endcase
            do_op(ra, rb);
        end
        in_valid = 1'b0;
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
